sat_engine_sched: RTL and testbench

Top-level sequencer for one SAT engine bin. Drives the variable-state list through a loop of imply, decide, conflict analysis and backtrack, using the list's `apply_*` strobes. It owns the current decision level. After each `start_i` it reports exactly one outcome on `done_o`/`result_o`: bin satisfied, UNSAT, a backtrack request to a level outside the bin, or an error.

---
 rtl/sat_engine_pkg.sv | 26 ++
 rtl/sched_stat_cnt.sv | 40 ++++
 rtl/sat_engine_sched.sv | 192 +++++++++++++++++++
 tb/tb_sat_engine_sched.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_engine_pkg.sv
// Shared definitions for the SAT engine bin sequencer.
// Provides the scheduler state encoding, the outcome codes reported on
// result_o, and the default decision-level width used across the engine.
package sat_engine_pkg;

  localparam int DEF_WIDTH_LVL = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IMPLY,
    S_IMPLY_CHK,
    S_DECIDE,
    S_ANALYZE,
    S_LEARN,
    S_BKT,
    S_DONE
  } sched_state_e;

  typedef enum logic [1:0] {
    RES_ERR   = 2'b00,
    RES_SAT   = 2'b01,
    RES_UNSAT = 2'b10,
    RES_GBKT  = 2'b11
  } sched_res_e;

endpackage

// File: rtl/sched_stat_cnt.sv
// Saturating statistics counter.
// Ports:
//   clk, rst   clock and synchronous active-low reset
//   clr_i      clear to zero (wins over inc_i)
//   inc_i      add one, sticking at all-ones
//   cnt_o      current count
module sched_stat_cnt
  import sat_engine_pkg::*;
#(
  parameter int WIDTH_CNT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [WIDTH_CNT-1:0] cnt_o
);

  logic [WIDTH_CNT-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH_CNT'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sat_engine_sched.sv
// Top-level sequencer for one SAT engine bin: runs the imply / decide /
// conflict-analysis / backtrack loop over the variable-state list and
// reports exactly one outcome per start.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   start_i, base_lvl_i, cur_lvl_i  begin solving; bin base and load level
//   decide_req_o / decide_valid_i / decide_none_i   decider handshake
//   apply_imply_o, new_imply_i, find_conflict_i     imply pass
//   apply_analyze_o, analyze_done_i, max_lvl_i      conflict analysis
//   apply_bkt_o, bkt_lvl_o                          backtrack strobe/target
//   cur_lvl_o, busy_o, done_o, result_o             status and outcome
//   conflict_cnt_o, decide_cnt_o                    saturating statistics
module sat_engine_sched
  import sat_engine_pkg::*;
#(
  parameter int WIDTH_LVL      = DEF_WIDTH_LVL,
  parameter int MAX_IMPLY_ITER = 64,
  parameter int WIDTH_CNT      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [WIDTH_LVL-1:0] base_lvl_i,
  input  logic [WIDTH_LVL-1:0] cur_lvl_i,
  output logic                 decide_req_o,
  input  logic                 decide_valid_i,
  input  logic                 decide_none_i,
  output logic                 apply_imply_o,
  input  logic                 new_imply_i,
  input  logic                 find_conflict_i,
  output logic                 apply_analyze_o,
  input  logic                 analyze_done_i,
  input  logic [WIDTH_LVL-1:0] max_lvl_i,
  output logic                 apply_bkt_o,
  output logic [WIDTH_LVL-1:0] bkt_lvl_o,
  output logic [WIDTH_LVL-1:0] cur_lvl_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           result_o,
  output logic [WIDTH_CNT-1:0] conflict_cnt_o,
  output logic [WIDTH_CNT-1:0] decide_cnt_o
);

  localparam int ICNT_W = $clog2(MAX_IMPLY_ITER + 1);
  localparam logic [ICNT_W-1:0] ICNT_MAX = ICNT_W'(MAX_IMPLY_ITER);

  sched_state_e         state_q, state_d;
  sched_res_e           result_q, result_d;
  logic [WIDTH_LVL-1:0] base_q, base_d;
  logic [WIDTH_LVL-1:0] cur_lvl_q, cur_lvl_d;
  logic [WIDTH_LVL-1:0] bkt_lvl_q, bkt_lvl_d;
  logic [ICNT_W-1:0]    icnt_q, icnt_d;
  logic                 cnt_clr, ccnt_inc, dcnt_inc;
  logic                 root_conflict;

  // A conflict at level 0 of a bin rooted at level 0 has nothing to undo.
  assign root_conflict = (cur_lvl_q == '0) && (base_q == '0);

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    base_d    = base_q;
    cur_lvl_d = cur_lvl_q;
    bkt_lvl_d = bkt_lvl_q;
    icnt_d    = icnt_q;
    cnt_clr   = 1'b0;
    ccnt_inc  = 1'b0;
    dcnt_inc  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          base_d    = base_lvl_i;
          cur_lvl_d = cur_lvl_i;
          icnt_d    = '0;
          cnt_clr   = 1'b1;
          state_d   = S_IMPLY;
        end
      end
      S_IMPLY: begin
        icnt_d  = icnt_q + ICNT_W'(1);
        state_d = S_IMPLY_CHK;
      end
      S_IMPLY_CHK: begin
        if (find_conflict_i) begin
          ccnt_inc = 1'b1;
          state_d  = S_ANALYZE;
        end else if (new_imply_i) begin
          if (icnt_q < ICNT_MAX) begin
            state_d = S_IMPLY;
          end else begin
            result_d = RES_ERR;
            state_d  = S_DONE;
          end
        end else begin
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (decide_none_i) begin
          result_d = RES_SAT;
          state_d  = S_DONE;
        end else if (decide_valid_i) begin
          // Level counter must not wrap; running out of levels is an error.
          if (cur_lvl_q == '1) begin
            result_d = RES_ERR;
            state_d  = S_DONE;
          end else begin
            cur_lvl_d = cur_lvl_q + WIDTH_LVL'(1);
            dcnt_inc  = 1'b1;
            icnt_d    = '0;
            state_d   = S_IMPLY;
          end
        end
      end
      S_ANALYZE: begin
        if (root_conflict) begin
          result_d = RES_UNSAT;
          state_d  = S_DONE;
        end else if (analyze_done_i) begin
          state_d = S_LEARN;
        end
      end
      S_LEARN: begin
        bkt_lvl_d = max_lvl_i;
        if (max_lvl_i < base_q) begin
          result_d = RES_GBKT;
          state_d  = S_DONE;
        end else begin
          state_d = S_BKT;
        end
      end
      S_BKT: begin
        cur_lvl_d = bkt_lvl_q;
        icnt_d    = '0;
        state_d   = S_IMPLY;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      result_q  <= RES_ERR;
      base_q    <= '0;
      cur_lvl_q <= '0;
      bkt_lvl_q <= '0;
      icnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      base_q    <= base_d;
      cur_lvl_q <= cur_lvl_d;
      bkt_lvl_q <= bkt_lvl_d;
      icnt_q    <= icnt_d;
    end
  end

  sched_stat_cnt #(.WIDTH_CNT(WIDTH_CNT)) u_conflict_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .inc_i (ccnt_inc),
    .cnt_o (conflict_cnt_o)
  );

  sched_stat_cnt #(.WIDTH_CNT(WIDTH_CNT)) u_decide_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .inc_i (dcnt_inc),
    .cnt_o (decide_cnt_o)
  );

  // Strobes decode the registered state only, so they are glitch-free and
  // mutually exclusive.
  assign decide_req_o    = (state_q == S_DECIDE);
  assign apply_imply_o   = (state_q == S_IMPLY);
  assign apply_analyze_o = (state_q == S_ANALYZE) && !root_conflict;
  assign apply_bkt_o     = (state_q == S_BKT);
  assign done_o          = (state_q == S_DONE);
  assign busy_o          = (state_q != S_IDLE);
  assign result_o        = result_q;
  assign cur_lvl_o       = cur_lvl_q;
  assign bkt_lvl_o       = bkt_lvl_q;

endmodule

// File: tb/tb_sat_engine_sched.sv
// Bench for sat_engine_sched: scenario tasks walk the solving rules, producing
// both the stimulus and the expected outputs of every cycle.
module tb_sat_engine_sched;

  localparam int LW   = 16;
  localparam int CW   = 32;
  localparam int MAXI = 64;

  localparam logic [3:0] STB_NONE = 4'b0000;
  localparam logic [3:0] STB_DEC  = 4'b1000;
  localparam logic [3:0] STB_IMP  = 4'b0100;
  localparam logic [3:0] STB_ANA  = 4'b0010;
  localparam logic [3:0] STB_BKT  = 4'b0001;

  localparam int NX_IMPLY = 0;
  localparam int NX_DEC   = 1;
  localparam int NX_ANA   = 2;
  localparam int NX_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [LW-1:0] base_lvl_i, cur_lvl_i, max_lvl_i;
  logic          decide_valid_i, decide_none_i, new_imply_i;
  logic          find_conflict_i, analyze_done_i;
  logic          decide_req_o, apply_imply_o, apply_analyze_o, apply_bkt_o;
  logic [LW-1:0] bkt_lvl_o, cur_lvl_o;
  logic          busy_o, done_o;
  logic [1:0]    result_o;
  logic [CW-1:0] conflict_cnt_o, decide_cnt_o;

  always #5 clk = ~clk;

  sat_engine_sched #(.WIDTH_LVL(LW), .MAX_IMPLY_ITER(MAXI), .WIDTH_CNT(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start_i),
    .base_lvl_i      (base_lvl_i),
    .cur_lvl_i       (cur_lvl_i),
    .decide_req_o    (decide_req_o),
    .decide_valid_i  (decide_valid_i),
    .decide_none_i   (decide_none_i),
    .apply_imply_o   (apply_imply_o),
    .new_imply_i     (new_imply_i),
    .find_conflict_i (find_conflict_i),
    .apply_analyze_o (apply_analyze_o),
    .analyze_done_i  (analyze_done_i),
    .max_lvl_i       (max_lvl_i),
    .apply_bkt_o     (apply_bkt_o),
    .bkt_lvl_o       (bkt_lvl_o),
    .cur_lvl_o       (cur_lvl_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .result_o        (result_o),
    .conflict_cnt_o  (conflict_cnt_o),
    .decide_cnt_o    (decide_cnt_o)
  );

  typedef struct {
    logic          rst_n;
    logic          start;
    logic [LW-1:0] base;
    logic [LW-1:0] cur;
    logic [LW-1:0] ml;
    logic          dv;
    logic          dn;
    logic          ni;
    logic          fc;
    logic          ad;
  } in_t;

  // Reference model of the externally visible bin state.
  logic [LW-1:0] m_cur, m_base, m_bkt;
  logic [1:0]    m_res;
  logic [CW-1:0] m_ccnt, m_dcnt;
  int            icnt;
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            obs_imply = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  function automatic in_t rnd();
    in_t r;
    r.rst_n = 1'b1;
    r.start = ($urandom_range(0, 3) == 0);
    r.base  = LW'($urandom);
    r.cur   = LW'($urandom);
    r.ml    = LW'($urandom);
    r.dv    = 1'($urandom);
    r.dn    = 1'($urandom);
    r.ni    = 1'($urandom);
    r.fc    = 1'($urandom);
    r.ad    = 1'($urandom);
    return r;
  endfunction

  // One cycle: compare what the DUT shows now, then drive this cycle's inputs.
  task automatic emit(input logic [3:0] stb, input logic busy, input logic done, input in_t in);
    @(negedge clk);
    cyc++;
    chk("decide_req_o", 64'(decide_req_o), 64'(stb[3]));
    chk("apply_imply_o", 64'(apply_imply_o), 64'(stb[2]));
    chk("apply_analyze_o", 64'(apply_analyze_o), 64'(stb[1]));
    chk("apply_bkt_o", 64'(apply_bkt_o), 64'(stb[0]));
    chk("busy_o", 64'(busy_o), 64'(busy));
    chk("done_o", 64'(done_o), 64'(done));
    chk("result_o", 64'(result_o), 64'(m_res));
    chk("cur_lvl_o", 64'(cur_lvl_o), 64'(m_cur));
    chk("bkt_lvl_o", 64'(bkt_lvl_o), 64'(m_bkt));
    chk("conflict_cnt_o", 64'(conflict_cnt_o), 64'(m_ccnt));
    chk("decide_cnt_o", 64'(decide_cnt_o), 64'(m_dcnt));
    if (apply_imply_o) obs_imply++;
    rst             = in.rst_n;
    start_i         = in.start;
    base_lvl_i      = in.base;
    cur_lvl_i       = in.cur;
    max_lvl_i       = in.ml;
    decide_valid_i  = in.dv;
    decide_none_i   = in.dn;
    new_imply_i     = in.ni;
    find_conflict_i = in.fc;
    analyze_done_i  = in.ad;
  endtask

  task automatic t_idle(input int n);
    in_t in;
    repeat (n) begin
      in = rnd();
      in.start = 1'b0;
      emit(STB_NONE, 1'b0, 1'b0, in);
    end
  endtask

  task automatic t_start(input logic [LW-1:0] b, input logic [LW-1:0] c);
    in_t in;
    in = rnd();
    in.start = 1'b1;
    in.base  = b;
    in.cur   = c;
    emit(STB_NONE, 1'b0, 1'b0, in);
    m_base = b;
    m_cur  = c;
    m_ccnt = '0;
    m_dcnt = '0;
    icnt   = 0;
  endtask

  task automatic t_done(input logic [1:0] res);
    m_res = res;
    emit(STB_NONE, 1'b1, 1'b1, rnd());
  endtask

  task automatic t_imply(input logic fc, input logic ni, output int nxt);
    in_t in;
    emit(STB_IMP, 1'b1, 1'b0, rnd());
    icnt++;
    in = rnd();
    in.fc = fc;
    in.ni = ni;
    emit(STB_NONE, 1'b1, 1'b0, in);
    if (fc) begin
      m_ccnt = sat_inc(m_ccnt);
      nxt = NX_ANA;
    end else if (ni) begin
      if (icnt < MAXI) begin
        nxt = NX_IMPLY;
      end else begin
        t_done(2'b00);
        nxt = NX_DONE;
      end
    end else begin
      nxt = NX_DEC;
    end
  endtask

  task automatic t_decide(input int wt, input logic none, input logic valid, output int nxt);
    in_t in;
    repeat (wt) begin
      in = rnd();
      in.dv = 1'b0;
      in.dn = 1'b0;
      emit(STB_DEC, 1'b1, 1'b0, in);
    end
    in = rnd();
    in.dv = valid;
    in.dn = none;
    emit(STB_DEC, 1'b1, 1'b0, in);
    if (none) begin
      t_done(2'b01);
      nxt = NX_DONE;
    end else if (m_cur == 16'hFFFF) begin
      t_done(2'b00);
      nxt = NX_DONE;
    end else begin
      m_cur  = m_cur + 16'd1;
      m_dcnt = sat_inc(m_dcnt);
      icnt   = 0;
      nxt    = NX_IMPLY;
    end
  endtask

  task automatic t_conflict(input int n, input logic [LW-1:0] ml, output int nxt);
    in_t in;
    if (m_cur == 0 && m_base == 0) begin
      emit(STB_NONE, 1'b1, 1'b0, rnd());
      t_done(2'b10);
      nxt = NX_DONE;
    end else begin
      for (int i = 0; i < n; i++) begin
        in = rnd();
        in.ad = (i == n - 1);
        emit(STB_ANA, 1'b1, 1'b0, in);
      end
      in = rnd();
      in.ml = ml;
      emit(STB_NONE, 1'b1, 1'b0, in);
      m_bkt = ml;
      if (ml < m_base) begin
        t_done(2'b11);
        nxt = NX_DONE;
      end else begin
        emit(STB_BKT, 1'b1, 1'b0, rnd());
        m_cur = m_bkt;
        icnt  = 0;
        nxt   = NX_IMPLY;
      end
    end
  endtask

  task automatic random_run();
    logic [LW-1:0] b, c, ml;
    int nxt, steps, span;
    logic none, lim;
    if ($urandom_range(0, 4) == 0) begin
      b = '0;
      c = '0;
    end else begin
      b = LW'($urandom_range(0, 20));
      c = b + LW'($urandom_range(0, 5));
    end
    t_start(b, c);
    nxt = NX_IMPLY;
    steps = 0;
    while (nxt != NX_DONE) begin
      steps++;
      lim = (steps < 25);
      case (nxt)
        NX_IMPLY: t_imply(lim && ($urandom_range(0, 4) == 0), lim && ($urandom_range(0, 2) == 0), nxt);
        NX_DEC: begin
          none = !lim || ($urandom_range(0, 5) == 0);
          t_decide($urandom_range(0, 2), none, none ? 1'($urandom) : 1'b1, nxt);
        end
        default: begin
          span = int'(m_cur) - int'(m_base);
          if (span < 0) span = 0;
          if (m_base > 0 && $urandom_range(0, 3) == 0) ml = m_base - 16'd1;
          else ml = m_base + LW'($urandom_range(0, span));
          t_conflict($urandom_range(1, 3), ml, nxt);
        end
      endcase
    end
    t_idle($urandom_range(0, 2));
  endtask

  initial begin
    int nxt, cs;
    in_t in;
    rst = 1'b0;
    start_i = 1'b0;
    base_lvl_i = '0;
    cur_lvl_i = '0;
    max_lvl_i = '0;
    decide_valid_i = 1'b0;
    decide_none_i = 1'b0;
    new_imply_i = 1'b0;
    find_conflict_i = 1'b0;
    analyze_done_i = 1'b0;
    m_cur = '0; m_base = '0; m_bkt = '0; m_res = 2'b00; m_ccnt = '0; m_dcnt = '0; icnt = 0;
    repeat (2) @(posedge clk);
    t_idle(2);

    // Immediate SAT from level 0.
    t_start(16'd0, 16'd0);
    cs = cyc;
    t_imply(1'b0, 1'b0, nxt);
    t_decide(0, 1'b1, 1'b0, nxt);
    chk("t1_done_latency", 64'(cyc - cs), 64'd4);
    chk("t1_result", 64'(result_o), 64'd1);
    chk("t1_cur_lvl", 64'(cur_lvl_o), 64'd0);
    t_idle(1);

    // Two decisions 3->4->5, then conflict backtracking to 4.
    t_start(16'd3, 16'd3);
    t_imply(1'b0, 1'b0, nxt);
    t_decide(1, 1'b0, 1'b1, nxt);
    t_imply(1'b0, 1'b0, nxt);
    t_decide(0, 1'b0, 1'b1, nxt);
    t_imply(1'b1, 1'b0, nxt);
    chk("t2_cur_lvl", 64'(cur_lvl_o), 64'd5);
    chk("t2_decide_cnt", 64'(decide_cnt_o), 64'd2);
    cs = cyc;
    t_conflict(3, 16'd4, nxt);
    chk("t3_bkt_latency", 64'(cyc - cs), 64'd5);
    chk("t3_apply_bkt", 64'(apply_bkt_o), 64'd1);
    chk("t3_bkt_lvl", 64'(bkt_lvl_o), 64'd4);
    chk("t3_conflict_cnt", 64'(conflict_cnt_o), 64'd1);
    t_imply(1'b0, 1'b0, nxt);
    chk("t3_cur_after_bkt", 64'(cur_lvl_o), 64'd4);
    t_decide(0, 1'b1, 1'b1, nxt);
    t_idle(1);

    // Learnt level below the bin base: global backtrack.
    t_start(16'd3, 16'd5);
    t_imply(1'b1, 1'b0, nxt);
    t_conflict(1, 16'd2, nxt);
    chk("t4_result", 64'(result_o), 64'd3);
    chk("t4_bkt_lvl", 64'(bkt_lvl_o), 64'd2);
    t_idle(2);

    // Reset in the middle of analysis.
    t_start(16'd3, 16'd5);
    t_imply(1'b1, 1'b0, nxt);
    in = rnd();
    in.rst_n = 1'b0;
    in.ad = 1'b0;
    emit(STB_ANA, 1'b1, 1'b0, in);
    m_cur = '0; m_base = '0; m_bkt = '0; m_res = 2'b00; m_ccnt = '0; m_dcnt = '0; icnt = 0;
    t_idle(1);
    chk("t7_busy", 64'(busy_o), 64'd0);
    chk("t7_result", 64'(result_o), 64'd0);
    chk("t7_bkt_lvl", 64'(bkt_lvl_o), 64'd0);
    chk("t7_conflict_cnt", 64'(conflict_cnt_o), 64'd0);
    t_idle(3);

    // Conflict at root level: UNSAT, no analysis strobe.
    t_start(16'd0, 16'd0);
    t_imply(1'b1, 1'b0, nxt);
    t_conflict(2, 16'd0, nxt);
    chk("t5_result", 64'(result_o), 64'd2);
    t_idle(1);

    // Imply never settles: error after MAX_IMPLY_ITER strobes.
    obs_imply = 0;
    t_start(16'd2, 16'd7);
    nxt = NX_IMPLY;
    while (nxt == NX_IMPLY) t_imply(1'b0, 1'b1, nxt);
    chk("t6_result", 64'(result_o), 64'd0);
    chk("t6_imply_pulses", 64'(obs_imply), 64'd64);
    t_idle(1);

    // Decision at the top level: error instead of wrapping.
    t_start(16'd0, 16'hFFFF);
    t_imply(1'b0, 1'b0, nxt);
    t_decide(0, 1'b0, 1'b1, nxt);
    chk("t9_result", 64'(result_o), 64'd0);
    chk("t9_cur_lvl", 64'(cur_lvl_o), 64'hFFFF);
    t_idle(1);

    for (int r = 0; r < 40; r++) random_run();
    t_idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
